// File: rtl/fifo_rd_stream_if.sv
// Valid/ready word stream produced by the FIFO read-side drain engine.
interface fifo_rd_stream_if #(
    parameter int unsigned WIDTH = 8
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a registered-read-port FIFO into a bubble-free valid/ready stream using a
// 2-entry output buffer plus tracking of the single read that may be in flight.
module fifo_rd_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_,
    output logic                  fifo_rden,
    input  logic                  fifo_rdempty,
    input  logic [WIDTH-1:0]      fifo_dataout,
    fifo_rd_stream_if.master      m_if,
    input  logic                  flush,
    output logic [CNT_W-1:0]      word_cnt,
    output logic                  busy
);

    logic [1:0]       occ_q, occ_d, occ_after;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       level;
    logic             pop;

    always_comb begin
        pop        = (occ_q != 2'd0) & m_if.m_ready;
        // Words held after this edge if no new read were issued; a read is allowed
        // only while that leaves room for the word it will return.
        level      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rden  = reset_ & !fifo_rdempty & !flush & (level < 3'd2);
        cnt_d      = cnt_q + {{(CNT_W - 1){1'b0}}, pop};
        occ_after  = occ_q - {1'b0, pop};
        e0_d       = e0_q;
        e1_d       = e1_q;
        if (pop) begin
            e0_d = e1_q;
        end
        if (inflight_q) begin
            if (occ_after == 2'd0) begin
                e0_d = fifo_dataout;
            end else begin
                e1_d = fifo_dataout;
            end
        end
        occ_d      = occ_after + {1'b0, inflight_q};
        inflight_d = fifo_rden;
        if (flush) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            e0_q       <= '0;
            e1_q       <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
            cnt_q      <= cnt_d;
        end
    end

    assign m_if.m_valid = (occ_q != 2'd0);
    assign m_if.m_data  = e0_q;
    assign word_cnt     = cnt_q;
    assign busy         = (occ_q != 2'd0) | inflight_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream against a small registered-read FIFO model.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        reset_;
    logic        flush;
    logic        m_ready;
    logic        fifo_rden, fifo_rden4;
    logic        fifo_rdempty;
    logic [7:0]  fifo_dataout = 8'h00;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt4;
    logic        busy, busy4;

    logic [7:0]  mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fifo_rd_stream_if #(.WIDTH(8)) s_if ();
    fifo_rd_stream_if #(.WIDTH(8)) s4_if ();

    assign s_if.m_ready  = m_ready;
    assign s4_if.m_ready = m_ready;
    assign fifo_rdempty  = (wr_ptr == rd_ptr);

    // Registered read port: data appears the cycle after rden is accepted.
    always @(posedge clk) begin
        if (fifo_rden) begin
            fifo_dataout <= mem[rd_ptr % 256];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) dut (
        .clk          (clk),
        .reset_       (reset_),
        .fifo_rden    (fifo_rden),
        .fifo_rdempty (fifo_rdempty),
        .fifo_dataout (fifo_dataout),
        .m_if         (s_if),
        .flush        (flush),
        .word_cnt     (word_cnt),
        .busy         (busy)
    );

    // Narrow-counter copy sees identical inputs, so it issues identical reads.
    fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk          (clk),
        .reset_       (reset_),
        .fifo_rden    (fifo_rden4),
        .fifo_rdempty (fifo_rdempty),
        .fifo_dataout (fifo_dataout),
        .m_if         (s4_if),
        .flush        (flush),
        .word_cnt     (word_cnt4),
        .busy         (busy4)
    );

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 256] = d;
        wr_ptr++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_  = 1'b1;
    endtask

    task automatic test_reset();
        int got;
        push(8'hAA);
        push(8'hBB);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (fifo_rden !== 1'b0 || s_if.m_valid !== 1'b0 || word_cnt !== 16'd0 ||
                busy !== 1'b0 || s_if.m_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_state: rden=%b valid=%b cnt=%0d busy=%b data=%h, need 0 0 0 0 00",
                         fifo_rden, s_if.m_valid, word_cnt, busy, s_if.m_data);
            end
        end
        @(negedge clk);
        reset_ = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            #1;
            if (s_if.m_valid && m_ready) begin
                checks++;
                if (s_if.m_data !== ((got == 0) ? 8'hAA : 8'hBB)) begin
                    errors++;
                    $display("FAIL reset_drain[%0d]: got %h", got, s_if.m_data);
                end
                got++;
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (got !== 2 || word_cnt !== 16'd2 || word_cnt4 !== 4'd2) begin
            errors++;
            $display("FAIL reset_drain_count: got %0d cnt=%0d cnt4=%0d, need 2 2 2",
                     got, word_cnt, word_cnt4);
        end
    endtask

    task automatic test_stream();
        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i));
        #1;
        checks++;
        if (fifo_rden !== 1'b1 || s_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_first_rden: rden=%b valid=%b, need 1 0", fifo_rden, s_if.m_valid);
        end
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk);
            #1;
            checks++;
            if (cyc == 1) begin
                if (s_if.m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_latency: valid=%b one cycle after rden, need 0",
                             s_if.m_valid);
                end
            end else if (cyc <= 17) begin
                if (s_if.m_valid !== 1'b1 || s_if.m_data !== 8'(cyc - 1)) begin
                    errors++;
                    $display("FAIL stream_word cyc%0d: valid=%b data=%h, need 1 %h",
                             cyc, s_if.m_valid, s_if.m_data, 8'(cyc - 1));
                end
            end else if (s_if.m_valid !== 1'b0 || word_cnt !== 16'd16 || word_cnt4 !== 4'd0) begin
                errors++;
                $display("FAIL stream_end: valid=%b cnt=%0d cnt4=%0d, need 0 16 0",
                         s_if.m_valid, word_cnt, word_cnt4);
            end
        end
    endtask

    task automatic test_backpressure();
        int got;
        do_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'(i));
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (cyc >= 2) begin
                checks++;
                if (fifo_rden !== 1'b0 || s_if.m_valid !== 1'b1 || s_if.m_data !== 8'h01) begin
                    errors++;
                    $display("FAIL bp_hold cyc%0d: rden=%b valid=%b data=%h, need 0 1 01",
                             cyc, fifo_rden, s_if.m_valid, s_if.m_data);
                end
            end
            @(negedge clk);
        end
        m_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            #1;
            if (s_if.m_valid) begin
                checks++;
                if (s_if.m_data !== 8'(got + 1)) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h need %h", got, s_if.m_data, 8'(got + 1));
                end
                got++;
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (got !== 5 || s_if.m_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== 16'd5) begin
            errors++;
            $display("FAIL bp_end: words=%0d valid=%b busy=%b cnt=%0d, need 5 0 0 5",
                     got, s_if.m_valid, busy, word_cnt);
        end
    endtask

    task automatic test_random_ready();
        int got, reads, pops;
        do_reset();
        for (int i = 0; i < 64; i++) push(8'((i * 37 + 5) % 256));
        got   = 0;
        reads = 0;
        pops  = 0;
        for (int c = 0; c < 2000 && got < 64; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (reads - pops > 3) begin
                errors++;
                $display("FAIL rand_outstanding: %0d words held or in flight, limit 3", reads - pops);
            end
            if (fifo_rden) reads++;
            if (s_if.m_valid && m_ready) begin
                checks++;
                if (s_if.m_data !== 8'((got * 37 + 5) % 256)) begin
                    errors++;
                    $display("FAIL rand_order[%0d]: got %h need %h",
                             got, s_if.m_data, 8'((got * 37 + 5) % 256));
                end
                got++;
                pops++;
            end
            @(negedge clk);
        end
        checks++;
        if (got !== 64) begin
            errors++;
            $display("FAIL rand_count: got %0d words, need 64", got);
        end
    endtask

    task automatic test_flush();
        int got;
        do_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(8'(8'h30 + i));
        repeat (3) @(negedge clk);
        m_ready = 1'b1;
        #1;
        checks++;
        if (s_if.m_valid !== 1'b1 || s_if.m_data !== 8'h31 || fifo_rden !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: valid=%b data=%h rden=%b, need 1 31 1",
                     s_if.m_valid, s_if.m_data, fifo_rden);
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (fifo_rden !== 1'b0 || busy !== 1'b1 || s_if.m_data !== 8'h32) begin
            errors++;
            $display("FAIL flush_cycle: rden=%b busy=%b data=%h, need 0 1 32",
                     fifo_rden, busy, s_if.m_data);
        end
        @(negedge clk);
        flush   = 1'b0;
        m_ready = 1'b0;
        #1;
        checks++;
        if (s_if.m_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== 16'd2) begin
            errors++;
            $display("FAIL flush_after: valid=%b busy=%b cnt=%0d, need 0 0 2",
                     s_if.m_valid, busy, word_cnt);
        end
        @(negedge clk);
        m_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            #1;
            if (s_if.m_valid) begin
                checks++;
                if (s_if.m_data !== 8'(8'h34 + got)) begin
                    errors++;
                    $display("FAIL flush_resume[%0d]: got %h need %h",
                             got, s_if.m_data, 8'(8'h34 + got));
                end
                got++;
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (got !== 3 || word_cnt !== 16'd5) begin
            errors++;
            $display("FAIL flush_end: words=%0d cnt=%0d, need 3 5", got, word_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(8'(8'h50 + i));
        repeat (25) @(negedge clk);
        #1;
        checks++;
        if (word_cnt4 !== 4'd1 || word_cnt !== 16'd17) begin
            errors++;
            $display("FAIL wrap: cnt4=%0d cnt16=%0d, need 1 17", word_cnt4, word_cnt);
        end
    endtask

    initial begin
        reset_  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_random_ready();
        test_flush();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
